vme_cmd_arbiter: RTL and testbench

Synthesizable arbiter that shares the single VME command engine among `NREQ` internal requesters (slow-control, BPI, test-control, monitoring). It round-robin grants one requester at a time and forms the masked 32-bit VME command word. It issues a one-cycle `start`, waits for engine completion or a timeout, and returns read data plus an acknowledge to the granted requester. It sits between the requester blocks and the VME command engine, driving the same `start`/`vme_cmd_reg`/`vme_dat_reg_in` interface that engine consumes.

---
 rtl/vme_cmd_arbiter_pkg.sv | 27 ++
 rtl/vme_cmd_arbiter_if.sv | 38 +++
 rtl/vme_cmd_arbiter_rr_arbiter.sv | 31 +++
 rtl/vme_cmd_arbiter.sv | 155 +++++++++++++++
 tb/tb_vme_cmd_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vme_cmd_arbiter_pkg.sv
// Shared types and constants for the VME command arbiter.
package vme_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam logic [31:0] MASK_DEFAULT = 32'h00A8_0000;
  localparam int          CMD_RD_BIT   = 25;
  localparam int          CMD_WR_BIT   = 24;
  localparam logic [15:0] ERR_DATA     = 16'hFFFF;
  localparam int          TIMEOUT_W    = 10;

  // Full command word: constant mask, 16-bit instruction, and direction bit.
  function automatic logic [31:0] build_cmd(input logic [31:0] mask,
                                            input logic [15:0] cmd,
                                            input logic        rd);
    logic [31:0] w;
    w = mask | {16'h0000, cmd};
    if (rd) w[CMD_RD_BIT] = 1'b1;
    else    w[CMD_WR_BIT] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/vme_cmd_arbiter_if.sv
// Bundle of requester-side and engine-side signals around the arbiter.
interface vme_cmd_arbiter_if #(
  parameter int NREQ = 4
);
  // Requester side
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_rd;
  logic [NREQ*16-1:0] req_cmd;
  logic [NREQ*16-1:0] req_dat;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    err;
  logic [15:0]        rsp_dat;
  logic               busy;

  // VME command engine side
  logic               vme_cmd_rd;
  logic               vme_dat_wr;
  logic [31:0]        vme_dat_reg_out;
  logic               start;
  logic [31:0]        vme_cmd_reg;
  logic [31:0]        vme_dat_reg_in;

  // Arbiter view
  modport slave (
    input  req, req_rd, req_cmd, req_dat,
    input  vme_cmd_rd, vme_dat_wr, vme_dat_reg_out,
    output ack, err, rsp_dat, busy,
    output start, vme_cmd_reg, vme_dat_reg_in
  );

  // Environment view (requesters plus engine)
  modport master (
    output req, req_rd, req_cmd, req_dat,
    output vme_cmd_rd, vme_dat_wr, vme_dat_reg_out,
    input  ack, err, rsp_dat, busy,
    input  start, vme_cmd_reg, vme_dat_reg_in
  );
endinterface

// File: rtl/vme_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last grant.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  int cand;

  // First requester found walking upward from ptr+1, wrapping at NREQ.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(ptr) + off) % NREQ;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/vme_cmd_arbiter.sv
// Shares one VME command engine among NREQ requesters: round-robin grant,
// one-cycle start with masked command word, completion or timeout ack.
module vme_cmd_arbiter
  import vme_arb_pkg::*;
#(
  parameter int          NREQ    = 4,
  parameter logic [31:0] MASK    = MASK_DEFAULT,
  parameter int          TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  vme_cmd_arbiter_if.slave bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]      gnt_oh_q, gnt_oh_d;
  logic                 rd_q, rd_d;
  logic [15:0]          cmd_q, cmd_d;
  logic [15:0]          dat_q, dat_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 start_q, start_d;
  logic [NREQ-1:0]      ack_q, ack_d;
  logic [NREQ-1:0]      err_q, err_d;
  logic [15:0]          rsp_q, rsp_d;
  logic [31:0]          cmd_reg_q, cmd_reg_d;
  logic [31:0]          dat_reg_q, dat_reg_d;
  logic                 busy_q, busy_d;

  logic [NREQ-1:0]      arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic                 unused_hi;

  // Upper half of the engine result carries nothing for the requesters.
  assign unused_hi = ^bus.vme_dat_reg_out[31:16];

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req         (bus.req),
    .ptr         (ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Next-state and registered-output logic for IDLE/ISSUE/WAIT.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_oh_d  = gnt_oh_q;
    rd_d      = rd_q;
    cmd_d     = cmd_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    ack_d     = '0;
    err_d     = '0;
    rsp_d     = '0;
    cmd_reg_d = MASK;
    dat_reg_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          ptr_d    = arb_idx;
          gnt_oh_d = arb_grant;
          rd_d     = bus.req_rd[arb_idx];
          cmd_d    = bus.req_cmd[int'(arb_idx)*16 +: 16];
          dat_d    = bus.req_dat[int'(arb_idx)*16 +: 16];
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if ((bus.req & gnt_oh_q) == '0) begin
          state_d = ST_IDLE;
        end else if (bus.vme_cmd_rd) begin
          state_d   = ST_WAIT;
          start_d   = 1'b1;
          cnt_d     = '0;
          cmd_reg_d = build_cmd(MASK, cmd_q, rd_q);
          dat_reg_d = rd_q ? 32'h0 : {16'h0000, dat_q};
        end
      end

      ST_WAIT: begin
        if (bus.vme_dat_wr) begin
          ack_d   = gnt_oh_q;
          rsp_d   = rd_q ? bus.vme_dat_reg_out[15:0] : dat_q;
          state_d = ST_IDLE;
        end else if (cnt_q == TIMEOUT_W'(TIMEOUT)) begin
          ack_d   = gnt_oh_q;
          err_d   = gnt_oh_q;
          rsp_d   = ERR_DATA;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, latched request and output registers; async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IDX_W'(NREQ - 1);
      gnt_oh_q  <= '0;
      rd_q      <= 1'b0;
      cmd_q     <= '0;
      dat_q     <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      ack_q     <= '0;
      err_q     <= '0;
      rsp_q     <= '0;
      cmd_reg_q <= MASK;
      dat_reg_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_oh_q  <= gnt_oh_d;
      rd_q      <= rd_d;
      cmd_q     <= cmd_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rsp_q     <= rsp_d;
      cmd_reg_q <= cmd_reg_d;
      dat_reg_q <= dat_reg_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.start          = start_q;
  assign bus.ack            = ack_q;
  assign bus.err            = err_q;
  assign bus.rsp_dat        = rsp_q;
  assign bus.busy           = busy_q;
  assign bus.vme_cmd_reg    = cmd_reg_q;
  assign bus.vme_dat_reg_in = dat_reg_q;

endmodule

// File: tb/tb_vme_cmd_arbiter.sv
// Testbench for vme_cmd_arbiter: transaction-level reference model with a
// per-cycle compare, directed literal cases, then randomized traffic.
module tb_vme_cmd_arbiter;

  localparam int          NREQ    = 4;
  localparam logic [31:0] MASK_C  = 32'h00A8_0000;
  localparam int          TIMEOUT = 1023;

  logic clk;
  logic rst_n;
  logic cmp_en;
  int   checks;
  int   errors;

  vme_cmd_arbiter_if #(.NREQ(NREQ)) bus ();

  vme_cmd_arbiter #(.NREQ(NREQ), .MASK(MASK_C), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something unforeseen stalls the run
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_owner;   // granted requester, -1 when no one holds the engine
  int          m_last;    // last granted requester
  bit          m_issued;  // start already sent for the current owner
  int          m_waited;  // cycles spent waiting for completion
  bit          m_rd;
  logic [15:0] m_cmd;
  logic [15:0] m_dat;

  logic            exp_start;
  logic [NREQ-1:0] exp_ack;
  logic [NREQ-1:0] exp_err;
  logic [15:0]     exp_rsp;
  logic            exp_busy;
  logic [31:0]     exp_cmd;
  logic [31:0]     exp_dat;

  // Model advances on each clock from the same inputs the DUT samples
  always @(posedge clk or negedge rst_n) begin
    exp_start = 1'b0;
    exp_ack   = '0;
    exp_err   = '0;
    exp_rsp   = '0;
    exp_cmd   = MASK_C;
    exp_dat   = '0;
    if (!rst_n) begin
      m_owner  = -1;
      m_last   = NREQ - 1;
      m_issued = 1'b0;
      m_waited = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (m_owner < 0 && bus.req[c]) begin
          m_owner  = c;
          m_last   = c;
          m_issued = 1'b0;
          m_rd     = bus.req_rd[c];
          m_cmd    = bus.req_cmd[c*16 +: 16];
          m_dat    = bus.req_dat[c*16 +: 16];
        end
      end
    end else if (!m_issued) begin
      if (!bus.req[m_owner]) begin
        m_owner = -1;
      end else if (bus.vme_cmd_rd) begin
        m_issued  = 1'b1;
        m_waited  = 0;
        exp_start = 1'b1;
        exp_cmd   = MASK_C | {16'h0000, m_cmd} | (m_rd ? 32'h0200_0000 : 32'h0100_0000);
        exp_dat   = m_rd ? 32'h0 : {16'h0000, m_dat};
      end
    end else begin
      m_waited++;
      if (bus.vme_dat_wr) begin
        exp_ack[m_owner] = 1'b1;
        exp_rsp = m_rd ? bus.vme_dat_reg_out[15:0] : m_dat;
        m_owner = -1;
      end else if (m_waited == TIMEOUT + 1) begin
        exp_ack[m_owner] = 1'b1;
        exp_err[m_owner] = 1'b1;
        exp_rsp = 16'hFFFF;
        m_owner = -1;
      end
    end
    exp_busy = (m_owner >= 0);
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("start", 32'(bus.start), 32'(exp_start));
      checkOutput("ack", 32'(bus.ack), 32'(exp_ack));
      checkOutput("err", 32'(bus.err), 32'(exp_err));
      checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
      checkOutput("vme_cmd_reg", bus.vme_cmd_reg, exp_cmd);
      checkOutput("vme_dat_reg_in", bus.vme_dat_reg_in, exp_dat);
      if (exp_ack != '0)
        checkOutput("rsp_dat", 32'(bus.rsp_dat), 32'(exp_rsp));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input int idx, input bit rd,
                               input logic [15:0] cmd, input logic [15:0] dat);
    bus.req_rd[idx]          = rd;
    bus.req_cmd[idx*16 +: 16] = cmd;
    bus.req_dat[idx*16 +: 16] = dat;
    bus.req[idx]             = 1'b1;
  endtask

  task automatic waitStart(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.start && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_start_seen"}, 32'(bus.start), 32'd1);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  int order [5];
  int exp_order [5];
  int n_ack, n_start, cyc, n;

  initial begin
    exp_order = '{0, 1, 2, 3, 0};
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    bus.req = '0; bus.req_rd = '0; bus.req_cmd = '0; bus.req_dat = '0;
    bus.vme_cmd_rd = 1'b0; bus.vme_dat_wr = 1'b0; bus.vme_dat_reg_out = '0;

    // Reset values
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    checkOutput("rst_start", 32'(bus.start), 32'd0);
    checkOutput("rst_ack", 32'(bus.ack), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    checkOutput("rst_rsp", 32'(bus.rsp_dat), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_cmd_reg", bus.vme_cmd_reg, 32'h00A8_0000);
    checkOutput("rst_dat_reg", bus.vme_dat_reg_in, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Single read by requester 1
    bus.vme_cmd_rd = 1'b1;
    applyStimulus(1, 1'b1, 16'h4100, 16'h0000);
    waitStart("rd");
    checkOutput("rd_cmd_word", bus.vme_cmd_reg, 32'h02A8_4100);
    checkOutput("rd_dat_word", bus.vme_dat_reg_in, 32'h0);
    bus.vme_dat_wr = 1'b1; bus.vme_dat_reg_out = 32'h0000_BEEF;
    @(negedge clk);
    bus.vme_dat_wr = 1'b0;
    checkOutput("rd_ack", 32'(bus.ack), 32'h2);
    checkOutput("rd_rsp", 32'(bus.rsp_dat), 32'h0000_BEEF);
    bus.req[1] = 1'b0;
    @(negedge clk);

    // Single write by requester 0
    applyStimulus(0, 1'b0, 16'h3000, 16'h0005);
    waitStart("wr");
    checkOutput("wr_cmd_word", bus.vme_cmd_reg, 32'h01A8_3000);
    checkOutput("wr_dat_word", bus.vme_dat_reg_in, 32'h0000_0005);
    bus.vme_dat_wr = 1'b1; bus.vme_dat_reg_out = 32'h0000_7777;
    @(negedge clk);
    bus.vme_dat_wr = 1'b0;
    checkOutput("wr_ack", 32'(bus.ack), 32'h1);
    checkOutput("wr_rsp", 32'(bus.rsp_dat), 32'h0005);
    bus.req[0] = 1'b0;

    // Fairness from a fresh pointer, all four requests held
    pulseReset();
    for (int i = 0; i < NREQ; i++)
      applyStimulus(i, i[0], 16'(16'h1000 + i), 16'(16'h00A0 + i));
    n_ack = 0; n_start = 0; cyc = 0;
    while (n_ack < 5 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.vme_dat_wr = bus.start;
      if (bus.start) n_start++;
      if (bus.ack != '0) begin
        for (int i = 0; i < NREQ; i++)
          if (bus.ack[i]) order[n_ack] = i;
        n_ack++;
      end
    end
    bus.req = '0;
    bus.vme_dat_wr = 1'b0;
    checkOutput("fair_acks", 32'(n_ack), 32'd5);
    checkOutput("fair_starts", 32'(n_start), 32'd5);
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("fair_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
    @(negedge clk);

    // Timeout: no completion after start
    applyStimulus(2, 1'b1, 16'h2222, 16'h0000);
    waitStart("to");
    n = 0;
    while (bus.ack == '0 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("to_cycles", 32'(n), 32'd1024);
    checkOutput("to_ack", 32'(bus.ack), 32'h4);
    checkOutput("to_err", 32'(bus.err), 32'h4);
    checkOutput("to_rsp", 32'(bus.rsp_dat), 32'hFFFF);
    bus.req[2] = 1'b0;
    @(negedge clk);

    // Completion in the same cycle as the timeout wins
    applyStimulus(2, 1'b1, 16'h2223, 16'h0000);
    waitStart("toc");
    for (int j = 1; j <= 1024; j++) begin
      @(negedge clk);
      if (j == 1023) begin
        bus.vme_dat_wr = 1'b1; bus.vme_dat_reg_out = 32'hABCD_1234;
      end
      if (j == 1024) bus.vme_dat_wr = 1'b0;
    end
    checkOutput("toc_ack", 32'(bus.ack), 32'h4);
    checkOutput("toc_err", 32'(bus.err), 32'h0);
    checkOutput("toc_rsp", 32'(bus.rsp_dat), 32'h1234);
    bus.req[2] = 1'b0;
    @(negedge clk);

    // Backpressure, then abort while waiting to issue
    bus.vme_cmd_rd = 1'b0;
    applyStimulus(3, 1'b0, 16'h3333, 16'h0033);
    n_start = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.start) n_start++;
    end
    checkOutput("bp_starts", 32'(n_start), 32'd0);
    checkOutput("bp_busy", 32'(bus.busy), 32'd1);
    bus.req[3] = 1'b0;
    n_ack = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.ack != '0) n_ack++;
    end
    checkOutput("abort_acks", 32'(n_ack), 32'd0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    bus.vme_cmd_rd = 1'b1;
    repeat (3) @(negedge clk);

    // Reset while waiting for completion
    applyStimulus(1, 1'b1, 16'h4101, 16'h0000);
    waitStart("rw");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rw_busy", 32'(bus.busy), 32'd0);
    checkOutput("rw_start", 32'(bus.start), 32'd0);
    checkOutput("rw_cmd_reg", bus.vme_cmd_reg, 32'h00A8_0000);
    checkOutput("rw_ack", 32'(bus.ack), 32'd0);
    bus.req = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    bus.vme_dat_wr = 1'b1; bus.vme_dat_reg_out = 32'h0000_5A5A;
    @(negedge clk);
    bus.vme_dat_wr = 1'b0;
    n_ack = (bus.ack != '0) ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ack != '0) n_ack++;
    end
    checkOutput("rw_late_acks", 32'(n_ack), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) #1 rst_n = 1'b0;
      if (i == 1503) #1 rst_n = 1'b1;
      bus.vme_cmd_rd      = ($urandom_range(0, 3) != 0);
      bus.vme_dat_wr      = ($urandom_range(0, 4) == 0);
      bus.vme_dat_reg_out = $urandom;
      for (int r = 0; r < NREQ; r++) begin
        if (bus.req[r]) begin
          if (bus.ack[r]) begin
            if ($urandom_range(0, 4) != 0) bus.req[r] = 1'b0;
          end else if ($urandom_range(0, 49) == 0) begin
            bus.req[r] = 1'b0;
          end
        end else if ($urandom_range(0, 4) == 0) begin
          applyStimulus(r, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        end
      end
    end
    bus.req = '0;
    bus.vme_dat_wr = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
